nios_processor_input_pio: RTL and testbench

// - Parametrised Avalon-MM input PIO for board switches/buttons. Successor to the single-bit, data-only switch port.
// - Adds WIDTH-bit input, a metastability synchroniser, a per-bit debouncer, edge capture and a maskable level IRQ to the Nios II.
// - Sits between the FPGA pins and the Nios II data master, on the system interconnect.

---
 rtl/nios_pio_pkg.sv | 29 ++
 rtl/nios_processor_debounce.sv | 58 +++++
 rtl/nios_processor_input_pio.sv | 87 ++++++++
 tb/tb_nios_processor_input_pio.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios II input PIO: register offsets, edge modes
// and the edge-detect helper used by the top level.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Per-bit edge pulses between the current and previous debounced value.
    function automatic logic [31:0] edge_bits(input int mode,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
        logic [31:0] rise;
        logic [31:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (mode)
            EDGE_RISING:  return rise;
            EDGE_FALLING: return fall;
            default:      return rise ^ fall;
        endcase
    endfunction

endpackage

// File: rtl/nios_processor_debounce.sv
// One input bit: metastability synchroniser followed by a stable-count debouncer.
// deb only follows the synchronised pin after DEBOUNCE_CYCLES consecutive mismatches.
module nios_processor_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    deb <= 1'b0;
                end else begin
                    deb <= s;
                end
            end
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // Any cycle where s agrees with deb restarts the count, so short glitches are dropped.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (s == deb) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/nios_processor_input_pio.sv
// Avalon-MM input PIO: debounced WIDTH-bit input, edge capture with W1C,
// maskable level interrupt and a registered read mux (latency 1).
module nios_processor_input_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] edge_hit;
    logic [31:0]      edge_full;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_processor_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (in_port[i]),
            .deb     (deb[i])
        );
    end

    assign wr_en       = chipselect & ~write_n;
    assign edge_full   = edge_bits(EDGE_TYPE, 32'(deb), 32'(deb_d));
    assign unused_bits = ^{writedata, edge_full};

    // Set is OR-ed in after the W1C clear so a same-cycle edge always survives.
    always_comb begin
        edge_hit     = edge_full[WIDTH-1:0];
        edgecap_next = edgecap;
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_next = edgecap & ~writedata[WIDTH-1:0];
        end
        edgecap_next = edgecap_next | edge_hit;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = deb;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_d    <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            deb_d    <= deb;
            edgecap  <= edgecap_next;
            readdata <= rd_next;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_processor_input_pio.sv
// Bench for the input PIO: three instances (rising, falling, any edge) share
// one bus and pin set; a monitor checks queued expected reads one cycle later.
module tb_nios_processor_input_pio;
    import nios_pio_pkg::*;

    localparam int W = 4;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [1:0]   address    = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n    = 1'b1;
    logic [31:0]  writedata  = 32'd0;
    logic [W-1:0] in_port    = '0;
    logic [31:0]  rd0, rd1, rd2;
    logic         irq0, irq1, irq2;

    always #5 clk = ~clk;

    nios_processor_input_pio #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
    nios_processor_input_pio #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_FALLING)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
    nios_processor_input_pio #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_ANY)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

    // Protocol: a read issued in the cycle before a rising edge presents readdata after that edge;
    // irq is compared at the same sample point, i.e. reflecting register state after that edge.
    typedef struct packed {
        logic [1:0]  dsel;
        logic        chk_irq;
        logic        irq;
        logic [31:0] rd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  issue = 1'b0;
    logic  mon_valid = 1'b0;

    always @(posedge clk) mon_valid <= issue;

    always @(negedge clk) begin
        exp_t        e;
        string       nm;
        logic [31:0] act_rd;
        logic        act_irq;
        if (mon_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL monitor_underflow: output presented with no expected entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (e.dsel)
                    2'd0:    begin act_rd = rd0; act_irq = irq0; end
                    2'd1:    begin act_rd = rd1; act_irq = irq1; end
                    default: begin act_rd = rd2; act_irq = irq2; end
                endcase
                if (act_rd !== e.rd || (e.chk_irq && act_irq !== e.irq)) begin
                    n_bad++;
                    $display("FAIL %s (dut %0d): got readdata=%h irq=%b, required readdata=%h irq=%b%s",
                             nm, e.dsel, act_rd, act_irq, e.rd, e.irq, e.chk_irq ? "" : " (irq not checked)");
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [1:0] d, input logic [31:0] rd,
                            input logic ci, input logic ir, input string nm);
        exp_t e;
        e.dsel = d; e.chk_irq = ci; e.irq = ir; e.rd = rd;
        address = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        issue = 1'b1;
        tick(1);
        issue = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Pin change just applied: data must hold old value for 6 edges and show new value on the 7th.
    task automatic data_latency(input logic [31:0] old_v, input logic [31:0] new_v, input string nm);
        for (int i = 1; i <= 7; i++) begin
            rd_check(ADDR_DATA, 2'd0, (i == 7) ? new_v : old_v, 1'b0, 1'b0, nm);
        end
    endtask

    initial begin
        // 1. reset with pins high, then release
        in_port = 4'hF;
        reset_n = 1'b0;
        tick(2);
        rd_check(ADDR_EDGECAP, 2'd0, 32'h0, 1'b1, 1'b0, "t1_reset_ec");
        rd_check(ADDR_DATA,    2'd2, 32'h0, 1'b1, 1'b0, "t1_reset_data");
        reset_n = 1'b1;
        data_latency(32'h0, 32'hF, "t1_data");
        rd_check(ADDR_EDGECAP, 2'd0, 32'hF, 1'b1, 1'b0, "t1_ec_rise");
        rd_check(ADDR_EDGECAP, 2'd1, 32'h0, 1'b1, 1'b0, "t1_ec_fall");
        rd_check(ADDR_EDGECAP, 2'd2, 32'hF, 1'b1, 1'b0, "t1_ec_any");
        in_port = 4'h0;
        tick(9);
        wr(ADDR_EDGECAP, 32'hF);
        rd_check(ADDR_EDGECAP, 2'd0, 32'h0, 1'b1, 1'b0, "t1_clr_rise");
        rd_check(ADDR_EDGECAP, 2'd1, 32'h0, 1'b1, 1'b0, "t1_clr_fall");

        // 2. clean edge, mask, W1C, reserved and read-only addresses
        in_port = 4'b0001;
        data_latency(32'h0, 32'h1, "t2_data");
        rd_check(ADDR_EDGECAP, 2'd0, 32'h1, 1'b1, 1'b0, "t2_ec");
        wr(ADDR_IRQMASK, 32'hFFFF_FFF1);
        rd_check(ADDR_IRQMASK, 2'd0, 32'h1, 1'b1, 1'b1, "t2_mask_irq");
        wr(ADDR_EDGECAP, 32'h1);
        rd_check(ADDR_EDGECAP, 2'd0, 32'h0, 1'b1, 1'b0, "t2_w1c");
        wr(ADDR_RSVD, 32'hFFFF_FFFF);
        rd_check(ADDR_RSVD, 2'd0, 32'h0, 1'b1, 1'b0, "t2_rsvd");
        wr(ADDR_DATA, 32'hF);
        rd_check(ADDR_DATA, 2'd0, 32'h1, 1'b1, 1'b0, "t2_data_ro");

        // 3. three-cycle glitch on bit1 must not pass
        in_port = 4'b0011;
        for (int i = 0; i < 3; i++) rd_check(ADDR_DATA, 2'd0, 32'h1, 1'b1, 1'b0, "t3_glitch_data");
        in_port = 4'b0001;
        for (int i = 0; i < 8; i++) rd_check(ADDR_DATA, 2'd0, 32'h1, 1'b1, 1'b0, "t3_glitch_data");
        rd_check(ADDR_EDGECAP, 2'd0, 32'h0, 1'b1, 1'b0, "t3_glitch_ec");

        // 4. W1C of 0x3 landing on the same edge that sets bit0
        in_port = 4'b0011;
        tick(9);
        rd_check(ADDR_EDGECAP, 2'd0, 32'h2, 1'b1, 1'b0, "t4_ec_pre");
        in_port = 4'b0010;
        tick(9);
        in_port = 4'b0011;
        tick(6);
        wr(ADDR_EDGECAP, 32'h3);
        rd_check(ADDR_EDGECAP, 2'd0, 32'h1, 1'b1, 1'b1, "t4_race");
        wr(ADDR_EDGECAP, 32'hF);

        // 5. one-cycle reset while bit2's count is 3
        in_port = 4'b0111;
        tick(5);
        reset_n = 1'b0;
        rd_check(ADDR_DATA, 2'd0, 32'h0, 1'b1, 1'b0, "t5_in_reset");
        reset_n = 1'b1;
        data_latency(32'h0, 32'h7, "t5_data");
        rd_check(ADDR_EDGECAP, 2'd0, 32'h7, 1'b1, 1'b0, "t5_ec");
        rd_check(ADDR_IRQMASK, 2'd0, 32'h0, 1'b1, 1'b0, "t5_mask");

        // 6. bit3 toggles on falling/any instances
        wr(ADDR_EDGECAP, 32'hF);
        in_port = 4'b1111;
        tick(9);
        rd_check(ADDR_EDGECAP, 2'd1, 32'h0, 1'b1, 1'b0, "t6_fall_on_rise");
        rd_check(ADDR_EDGECAP, 2'd2, 32'h8, 1'b1, 1'b0, "t6_any_on_rise");
        rd_check(ADDR_EDGECAP, 2'd0, 32'h8, 1'b1, 1'b0, "t6_rise_on_rise");
        wr(ADDR_EDGECAP, 32'hF);
        in_port = 4'b0111;
        tick(9);
        rd_check(ADDR_EDGECAP, 2'd1, 32'h8, 1'b1, 1'b0, "t6_fall_on_fall");
        rd_check(ADDR_EDGECAP, 2'd2, 32'h8, 1'b1, 1'b0, "t6_any_on_fall");
        rd_check(ADDR_EDGECAP, 2'd0, 32'h0, 1'b1, 1'b0, "t6_rise_on_fall");

        tick(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
